serdes_rx_deframer: RTL

SERDES_RX_DEFRAMER -- requirements
Module: serdes_rx_deframer

---
 rtl/serdes_rx_deframer_pkg.sv | 12 +
 rtl/serdes_rx_deframer_if.sv | 32 +++
 rtl/serdes_sync_fifo.sv | 63 ++++++
 rtl/serdes_rx_deframer.sv | 119 +++++++++++
 4 files changed

// File: rtl/serdes_rx_deframer_pkg.sv
// Shared constants and FSM state type for the serial receive deframer.
package serdes_rx_deframer_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 4;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/serdes_rx_deframer_if.sv
// Serial input, byte output and status bundle of the receive deframer.
interface serdes_rx_deframer_if
  import serdes_rx_deframer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic             i_start;
  logic             i_bit_valid;
  logic             i_bit_in;
  logic             i_out_ready;
  logic [WIDTH-1:0] o_out_data;
  logic             o_out_valid;
  logic [CW-1:0]    o_fifo_count;
  logic             o_frame_err;
  logic             o_overflow;
  logic             o_busy;

  modport master (
    output i_start, i_bit_valid, i_bit_in, i_out_ready,
    input  o_out_data, o_out_valid, o_fifo_count, o_frame_err, o_overflow, o_busy
  );

  modport slave (
    input  i_start, i_bit_valid, i_bit_in, i_out_ready,
    output o_out_data, o_out_valid, o_fifo_count, o_frame_err, o_overflow, o_busy
  );

endinterface

// File: rtl/serdes_sync_fifo.sv
// Single-clock FIFO; a push while full is accepted only alongside a real pop.
module serdes_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_pop_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full     = (r_count == CW'(DEPTH));
  assign o_empty    = (r_count == {CW{1'b0}});
  assign o_count    = r_count;
  assign w_do_pop   = i_pop && !o_empty;
  assign w_do_push  = i_push && (!o_full || w_do_pop);
  // Head is forced to zero while empty so the output idles at its reset value.
  assign o_pop_data = o_empty ? {WIDTH{1'b0}} : r_mem[r_rd_ptr];

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/serdes_rx_deframer.sv
// Assembles MSB-first serial bits into WIDTH-bit bytes and queues them.
module serdes_rx_deframer
  import serdes_rx_deframer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  serdes_rx_deframer_if.slave  bus
);

  localparam int BCW = $clog2(WIDTH);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [BCW-1:0]   r_bit_cnt;
  logic [BCW-1:0]   w_bit_cnt_nxt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_nxt;
  logic [WIDTH-1:0] w_assembled;
  logic             r_frame_err;
  logic             w_frame_err_nxt;
  logic             r_overflow;
  logic             w_last;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;

  assign w_assembled = {r_shift[WIDTH-2:0], bus.i_bit_in};
  assign w_last      = bus.i_bit_valid && (r_bit_cnt == LAST_BIT);
  assign w_pop       = bus.i_out_ready && !w_empty;

  // Next-state, counter and shift-register update.
  always_comb begin
    w_state_nxt     = r_state;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_shift_nxt     = r_shift;
    w_push          = 1'b0;
    w_frame_err_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.i_start) begin
          w_state_nxt   = ST_SHIFT;
          w_bit_cnt_nxt = {BCW{1'b0}};
          w_shift_nxt   = {WIDTH{1'b0}};
        end else begin
          w_state_nxt   = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (bus.i_start) begin
          // A start landing on the final bit still delivers that byte.
          w_push          = w_last;
          w_frame_err_nxt = !w_last && (r_bit_cnt != {BCW{1'b0}});
          w_state_nxt     = ST_SHIFT;
          w_bit_cnt_nxt   = {BCW{1'b0}};
          w_shift_nxt     = {WIDTH{1'b0}};
        end else if (bus.i_bit_valid) begin
          w_shift_nxt = w_assembled;
          if (w_last) begin
            w_push        = 1'b1;
            w_state_nxt   = ST_IDLE;
            w_bit_cnt_nxt = {BCW{1'b0}};
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + BCW'(1);
          end
        end else begin
          w_state_nxt = ST_SHIFT;
        end
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_bit_cnt_nxt = {BCW{1'b0}};
        w_shift_nxt   = {WIDTH{1'b0}};
      end
    endcase
  end

  // State, datapath and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= {BCW{1'b0}};
      r_shift     <= {WIDTH{1'b0}};
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_shift     <= w_shift_nxt;
      r_frame_err <= w_frame_err_nxt;
      r_overflow  <= r_overflow | (w_push & w_full & !w_pop);
    end
  end

  serdes_sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_data (w_assembled),
    .i_pop       (w_pop),
    .o_pop_data  (bus.o_out_data),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (bus.o_fifo_count)
  );

  assign bus.o_out_valid = !w_empty;
  assign bus.o_frame_err = r_frame_err;
  assign bus.o_overflow  = r_overflow;
  assign bus.o_busy      = (r_state == ST_SHIFT);

endmodule
